// File: rtl/wptr_handler_if.sv
// Write-side FIFO pointer bus: write request, synchronised read pointer, overflow clear,
// and the address, pointer and status flags returned by the write pointer handler.
interface wptr_handler_if #(
    parameter int ADDR_SIZE = 12
);
    logic                 winc;
    logic [ADDR_SIZE:0]   rptr_s;
    logic                 wclr_ovf;
    logic [ADDR_SIZE-1:0] waddr;
    logic [ADDR_SIZE:0]   wptr;
    logic                 wFull;
    logic                 wAlmostFull;
    logic [ADDR_SIZE:0]   wLevel;
    logic                 wOverflow;

    modport master (
        output winc, rptr_s, wclr_ovf,
        input  waddr, wptr, wFull, wAlmostFull, wLevel, wOverflow
    );

    modport slave (
        input  winc, rptr_s, wclr_ovf,
        output waddr, wptr, wFull, wAlmostFull, wLevel, wOverflow
    );
endinterface

// File: rtl/wptr_handler.sv
// Async-FIFO write pointer handler: binary/Gray write pointer, full and sticky overflow flags.
// Optional fill level and almost-full logic is compiled in when WPTR_ALMOST_FULL_EN is defined.
module wptr_handler #(
    parameter int ADDR_SIZE    = 12,
    parameter int AFULL_MARGIN = 4
) (
    input  logic          wclk,
    input  logic          wrst,
    wptr_handler_if.slave bus
);
    logic [ADDR_SIZE:0] r_wbin;
    logic [ADDR_SIZE:0] r_wptr;
    logic               r_wfull;
    logic               r_wovf;
    logic [ADDR_SIZE:0] w_wbinnext;
    logic [ADDR_SIZE:0] w_wgraynext;
    logic [ADDR_SIZE:0] w_rptr_full;
    logic               w_full_next;
    logic               w_ovf_next;

    assign w_wbinnext  = r_wbin + {{ADDR_SIZE{1'b0}}, (bus.winc & ~r_wfull)};
    assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

    // Full when the write pointer has lapped the read pointer by exactly one depth;
    // in Gray code that is the read pointer with its two MSBs inverted.
    assign w_rptr_full = {~bus.rptr_s[ADDR_SIZE:ADDR_SIZE-1], bus.rptr_s[ADDR_SIZE-2:0]};
    assign w_full_next = (w_wgraynext == w_rptr_full);

    // Setting dominates a simultaneous clear so no rejected write goes unreported.
    assign w_ovf_next  = (bus.winc & r_wfull) | (r_wovf & ~bus.wclr_ovf);

    always_ff @(posedge wclk) begin
        if (!wrst) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_wfull <= 1'b0;
            r_wovf  <= 1'b0;
        end else begin
            r_wbin  <= w_wbinnext;
            r_wptr  <= w_wgraynext;
            r_wfull <= w_full_next;
            r_wovf  <= w_ovf_next;
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    localparam int unsigned AFULL_TH_I = (1 << ADDR_SIZE) - AFULL_MARGIN;
    localparam logic [ADDR_SIZE:0] AFULL_TH = AFULL_TH_I[ADDR_SIZE:0];

    function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
        logic [ADDR_SIZE:0] b;
        b[ADDR_SIZE] = g[ADDR_SIZE];
        for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_SIZE:0] w_rbin_s;
    logic [ADDR_SIZE:0] w_level_next;
    logic [ADDR_SIZE:0] r_wlevel;
    logic               r_wafull;

    assign w_rbin_s     = gray2bin(bus.rptr_s);
    assign w_level_next = w_wbinnext - w_rbin_s;

    always_ff @(posedge wclk) begin
        if (!wrst) begin
            r_wlevel <= '0;
            r_wafull <= 1'b0;
        end else begin
            r_wlevel <= w_level_next;
            r_wafull <= (w_level_next >= AFULL_TH);
        end
    end

    assign bus.wLevel      = r_wlevel;
    assign bus.wAlmostFull = r_wafull;
`else
    assign bus.wLevel      = '0;
    assign bus.wAlmostFull = 1'b0;
`endif

    assign bus.waddr     = r_wbin[ADDR_SIZE-1:0];
    assign bus.wptr      = r_wptr;
    assign bus.wFull     = r_wfull;
    assign bus.wOverflow = r_wovf;
endmodule
